// File: rtl/uart_program_loader.sv
// ============================================================================
// Module   : uart_program_loader
// Purpose  : 8N1 UART receiver that writes received bytes to sequential memory
//            addresses while enable is high. Optional feature: LOADER_CHECKSUM_EN
//            adds checksum_out, the mod-256 sum of the written bytes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_program_loader #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx,
   input  logic       enable,
   output logic [7:0] address_out,
   output logic [7:0] data_out,
   output logic       wr_en_out,
   output logic       busy,
   output logic       frame_err,
   output logic [8:0] byte_count
`ifdef LOADER_CHECKSUM_EN
   ,
   output logic [7:0] checksum_out
`endif
);

   localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   rx_state_t   state;
   logic        rx_meta;
   logic        rx_sync;
   logic        rx_prev;
   logic        en_prev;
   logic [15:0] cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shift;
   logic        frame_ok;
   logic [7:0]  wr_addr;
   logic        rx_fall;
   logic        en_rise;

   assign rx_fall = rx_prev & ~rx_sync;
   assign en_rise = enable & ~en_prev;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= RX_IDLE;
         rx_meta     <= 1'b1;
         rx_sync     <= 1'b1;
         rx_prev     <= 1'b1;
         en_prev     <= 1'b0;
         cnt         <= '0;
         bit_idx     <= '0;
         shift       <= '0;
         frame_ok    <= 1'b0;
         wr_addr     <= '0;
         address_out <= '0;
         data_out    <= '0;
         wr_en_out   <= 1'b0;
         busy        <= 1'b0;
         frame_err   <= 1'b0;
         byte_count  <= '0;
      end else begin
         rx_meta   <= rx;
         rx_sync   <= rx_meta;
         rx_prev   <= rx_sync;
         en_prev   <= enable;
         wr_en_out <= 1'b0;
         // Any moment of enable low during a frame forfeits its write.
         frame_ok  <= frame_ok & enable;

         if (wr_en_out) begin
            wr_addr <= wr_addr + 8'd1;
            if (byte_count != 9'd256)
               byte_count <= byte_count + 9'd1;
         end

         case (state)
            RX_IDLE: begin
               if (rx_fall) begin
                  state    <= RX_START;
                  busy     <= 1'b1;
                  cnt      <= '0;
                  frame_ok <= enable;
               end
            end
            RX_START: begin
               if (cnt == HALF_LAST) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  if (rx_sync) begin
                     state <= RX_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state <= RX_DATA;
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            RX_DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt     <= '0;
                  shift   <= {rx_sync, shift[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7)
                     state <= RX_STOP;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            RX_STOP: begin
               if (cnt == BIT_LAST) begin
                  cnt <= '0;
                  if (rx_sync) begin
                     if (frame_ok && enable) begin
                        wr_en_out   <= 1'b1;
                        data_out    <= shift;
                        address_out <= wr_addr;
                     end
                  end else begin
                     frame_err <= 1'b1;
                  end
                  // A start edge coinciding with the exit goes straight back in.
                  if (rx_fall) begin
                     state    <= RX_START;
                     frame_ok <= enable;
                  end else begin
                     state <= RX_IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            default: begin
               state <= RX_IDLE;
               busy  <= 1'b0;
            end
         endcase

         if (en_rise) begin
            wr_addr    <= '0;
            byte_count <= '0;
            frame_err  <= 1'b0;
         end
      end
   end

`ifdef LOADER_CHECKSUM_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         checksum_out <= '0;
      else if (en_rise)
         checksum_out <= '0;
      else if (wr_en_out)
         checksum_out <= checksum_out + data_out;
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_program_loader.sv
// ============================================================================
// Module   : tb_uart_program_loader
// Purpose  : Self-checking bench for uart_program_loader against a byte-level
//            reference model. Honours LOADER_CHECKSUM_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_program_loader;

   localparam int CPB = 16;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       rx    = 1'b1;
   logic       enable = 1'b0;
   logic [7:0] address_out;
   logic [7:0] data_out;
   logic       wr_en_out;
   logic       busy;
   logic       frame_err;
   logic [8:0] byte_count;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0] checksum_out;
`endif

   uart_program_loader #(.CLKS_PER_BIT(CPB)) dut (
      .clock       (clock),
      .reset       (reset),
      .rx          (rx),
      .enable      (enable),
      .address_out (address_out),
      .data_out    (data_out),
      .wr_en_out   (wr_en_out),
      .busy        (busy),
      .frame_err   (frame_err),
      .byte_count  (byte_count)
`ifdef LOADER_CHECKSUM_EN
      ,
      .checksum_out(checksum_out)
`endif
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] d;
   } wr_t;
   wr_t exp_q[$];

   // Byte-level reference model
   int m_addr, m_count, m_ferr, m_last_a, m_last_d, m_cs, m_en;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clock);
   endtask

   task automatic model_clear();
      m_addr = 0; m_count = 0; m_ferr = 0; m_cs = 0;
   endtask

   task automatic set_enable(input logic v);
      @(posedge clock);
      enable = v;
      if (v && m_en == 0) model_clear();
      m_en = v;
      wait_clks(3);
   endtask

   task automatic check_status();
      #1;
      check("byte_count", byte_count, m_count);
      check("frame_err", frame_err, m_ferr);
      check("address_hold", address_out, m_last_a);
      check("data_hold", data_out, m_last_d);
      check("busy_idle", busy, 0);
      check("pending_writes", exp_q.size(), 0);
`ifdef LOADER_CHECKSUM_EN
      check("checksum", checksum_out, m_cs);
`endif
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stop, input logic drop_en, input int gap);
      wr_t e;
      if (m_en != 0 && stop && !drop_en) begin
         e.a = m_addr[7:0];
         e.d = d;
         exp_q.push_back(e);
         m_last_a = m_addr;
         m_last_d = d;
         m_addr   = (m_addr + 1) % 256;
         m_count  = (m_count < 256) ? m_count + 1 : 256;
         m_cs     = (m_cs + d) % 256;
      end
      if (!stop) m_ferr = 1;
      @(posedge clock);
      rx = 1'b0;
      wait_clks(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         if (i == 4) begin
            #1 check("busy_mid_frame", busy, 1);
         end
         if (i == 3 && drop_en) begin
            enable = 1'b0;
            m_en = 0;
         end
         wait_clks(CPB);
      end
      rx = stop;
      wait_clks(CPB);
      rx = 1'b1;
      wait_clks(gap + 1);
      check_status();
   endtask

   always @(negedge clock) begin : cmp
      wr_t e;
      if (!reset && wr_en_out) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", address_out, e.a);
            check("wr_data", data_out, e.d);
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL timeout: simulation did not finish");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

   initial begin
      m_addr = 0; m_count = 0; m_ferr = 0; m_last_a = 0; m_last_d = 0; m_cs = 0; m_en = 0;

      // Reset values
      wait_clks(4);
      #1;
      check("rst_address", address_out, 8'h00);
      check("rst_data", data_out, 8'h00);
      check("rst_wr_en", wr_en_out, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_byte_count", byte_count, 0);
      reset = 1'b0;
      wait_clks(3);
      set_enable(1'b1);

      // Single byte
      send_byte(8'hA5, 1'b1, 1'b0, 4);
      check("single_addr", address_out, 8'h00);
      check("single_data", data_out, 8'hA5);
      check("single_count", byte_count, 9'd1);

      // Framing error then enable toggle clears it
      send_byte(8'h3C, 1'b0, 1'b0, 4);
      check("ferr_set", frame_err, 1);
      check("ferr_addr_unchanged", address_out, 8'h00);
      set_enable(1'b0);
      set_enable(1'b1);
      #1 check("ferr_cleared", frame_err, 0);

      // Glitch on rx: short low pulse rejected without error
      @(posedge clock);
      rx = 1'b0;
      wait_clks(4);
      rx = 1'b1;
      wait_clks(20);
      #1;
      check("glitch_busy", busy, 0);
      check("glitch_ferr", frame_err, 0);

      // Byte with enable low is discarded
      set_enable(1'b0);
      send_byte(8'h5A, 1'b1, 1'b0, 4);

      // Enable falls mid-frame: frame completes unwritten
      set_enable(1'b1);
      send_byte(8'h44, 1'b1, 1'b0, 2);
      send_byte(8'h77, 1'b1, 1'b1, 4);
      set_enable(1'b1);

      // Reset during bit 3
      @(posedge clock);
      rx = 1'b0;
      wait_clks(CPB);
      for (int i = 0; i < 3; i++) begin
         rx = (8'h81 >> i) & 1;
         wait_clks(CPB);
      end
      rx = 1'b0;
      wait_clks(CPB / 2);
      reset = 1'b1;
      rx = 1'b1;
      wait_clks(2);
      #1;
      check("midrst_address", address_out, 8'h00);
      check("midrst_data", data_out, 8'h00);
      check("midrst_busy", busy, 0);
      check("midrst_byte_count", byte_count, 0);
      check("midrst_wr_en", wr_en_out, 0);
      m_last_a = 0; m_last_d = 0;
      model_clear();
      reset = 1'b0;
      wait_clks(5);
      send_byte(8'h81, 1'b1, 1'b0, 4);
      check("after_rst_addr", address_out, 8'h00);
      check("after_rst_data", data_out, 8'h81);

      // Randomized traffic
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 4) == 0)
            set_enable(m_en == 0);
         send_byte(8'($urandom), $urandom_range(0, 7) != 0, 1'b0, $urandom_range(0, 3));
      end

      // Address wrap and count saturation
      set_enable(1'b0);
      set_enable(1'b1);
      for (int n = 0; n < 257; n++)
         send_byte(8'(n % 256), 1'b1, 1'b0, 1);
      check("wrap_addr", address_out, 8'h00);
      check("wrap_data", data_out, 8'h00);
      check("wrap_count", byte_count, 9'd256);

`ifdef LOADER_CHECKSUM_EN
      set_enable(1'b0);
      set_enable(1'b1);
      send_byte(8'h10, 1'b1, 1'b0, 2);
      send_byte(8'h20, 1'b1, 1'b0, 2);
      send_byte(8'hF0, 1'b1, 1'b0, 2);
      check("checksum_literal", checksum_out, 8'h20);
`endif

      wait_clks(10);
      check("final_queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
